// File: rtl/stream_deserializer.sv
// rtl/stream_deserializer.sv - collects signed beats into a VEC_LEN-lane registered vector; optional macro STREAM_DESER_ERRCNT_EN adds err_cnt/clr_err_cnt
module stream_deserializer #(
   parameter int VEC_LEN = 3,
   parameter int DATA_W  = 32,
   parameter int CNT_W   = $clog2(VEC_LEN + 1)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [CNT_W-1:0]          cfg_len,
   input  logic                      s_valid,
   input  logic signed [DATA_W-1:0]  s_data,
   input  logic                      s_last,
   output logic                      s_ready,
`ifdef STREAM_DESER_ERRCNT_EN
   input  logic                      clr_err_cnt,
   output logic [15:0]               err_cnt,
`endif
   output logic                      m_valid,
   input  logic                      m_ready,
   output logic [VEC_LEN*DATA_W-1:0] m_data_flat,
   output logic [CNT_W-1:0]          m_count,
   output logic                      m_err_short,
   output logic                      m_err_long
);

   typedef enum logic [1:0] {S_FILL, S_WAIT, S_DROP} state_t;

   localparam logic [CNT_W-1:0] LEN_MAX = CNT_W'(VEC_LEN);

   state_t                    state, state_nxt;
   logic [CNT_W-1:0]          ptr, len_q, cur_len, ptr_inc;
   logic signed [DATA_W-1:0]  lanes [VEC_LEN];
   logic [VEC_LEN*DATA_W-1:0] frame_flat, held_flat;
   logic [CNT_W-1:0]          pend_count;
   logic                      pend_short, pend_long;
   logic                      beat, done, is_short, is_long;
   logic                      out_free, fill_done, load;

   // Frame length, completion and error classification for the current beat
   always_comb begin
      cur_len = len_q;
      if (ptr == '0)
         cur_len = (cfg_len == '0 || cfg_len > LEN_MAX) ? LEN_MAX : cfg_len;
      ptr_inc   = ptr + CNT_W'(1);
      beat      = s_valid && s_ready;
      done      = s_last || (ptr_inc == cur_len);
      is_short  = s_last && (ptr_inc < cur_len);
      is_long   = !s_last && (ptr_inc == cur_len);
      out_free  = !m_valid || m_ready;
      fill_done = (state == S_FILL) && beat && done;
   end

   // Completed-frame image: lanes so far plus this beat, unwritten lanes zeroed
   always_comb begin
      frame_flat = '0;
      held_flat  = '0;
      for (int i = 0; i < VEC_LEN; i++) begin
         if (CNT_W'(i) == ptr)
            frame_flat[i*DATA_W +: DATA_W] = s_data;
         else if (CNT_W'(i) < ptr)
            frame_flat[i*DATA_W +: DATA_W] = lanes[i];
         held_flat[i*DATA_W +: DATA_W] = lanes[i];
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= S_FILL;
      else     state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         S_FILL: if (fill_done) begin
                    if (!out_free)    state_nxt = S_WAIT;
                    else if (is_long) state_nxt = S_DROP;
                 end
         S_WAIT: if (out_free) state_nxt = pend_long ? S_DROP : S_FILL;
         S_DROP: if (beat && s_last) state_nxt = S_FILL;
         default: state_nxt = S_FILL;
      endcase
   end

   // FSM outputs: input handshake and output-register load strobe
   always_comb begin
      s_ready = (state != S_WAIT);
      load    = out_free && (fill_done || state == S_WAIT);
   end

   // Assembly buffer, pending frame and output register
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr         <= '0;
         len_q       <= '0;
         pend_count  <= '0;
         pend_short  <= 1'b0;
         pend_long   <= 1'b0;
         m_valid     <= 1'b0;
         m_data_flat <= '0;
         m_count     <= '0;
         m_err_short <= 1'b0;
         m_err_long  <= 1'b0;
         for (int i = 0; i < VEC_LEN; i++) lanes[i] <= '0;
      end else begin
         if (m_valid && m_ready) m_valid <= 1'b0;
         if (state == S_FILL && beat) begin
            if (ptr == '0) len_q <= cur_len;
            if (done) begin
               ptr <= '0;
               if (out_free) begin
                  m_valid     <= 1'b1;
                  m_data_flat <= frame_flat;
                  m_count     <= ptr_inc;
                  m_err_short <= is_short;
                  m_err_long  <= is_long;
               end else begin
                  for (int i = 0; i < VEC_LEN; i++)
                     lanes[i] <= frame_flat[i*DATA_W +: DATA_W];
                  pend_count <= ptr_inc;
                  pend_short <= is_short;
                  pend_long  <= is_long;
               end
            end else begin
               for (int i = 0; i < VEC_LEN; i++)
                  if (CNT_W'(i) == ptr) lanes[i] <= s_data;
               ptr <= ptr_inc;
            end
         end
         if (state == S_WAIT && out_free) begin
            m_valid     <= 1'b1;
            m_data_flat <= held_flat;
            m_count     <= pend_count;
            m_err_short <= pend_short;
            m_err_long  <= pend_long;
         end
      end
   end

`ifdef STREAM_DESER_ERRCNT_EN
   logic load_err;

   // Error flags of whichever frame is being loaded this cycle
   always_comb begin
      load_err = (state == S_WAIT) ? (pend_short | pend_long) : (is_short | is_long);
   end

   // Saturating count of errored frames; clear has priority
   always_ff @(posedge clk) begin
      if (rst || clr_err_cnt)
         err_cnt <= '0;
      else if (load && load_err && err_cnt != 16'hFFFF)
         err_cnt <= err_cnt + 16'd1;
   end
`endif

endmodule

// File: doc/stream_deserializer.md
Name: stream_deserializer

Overview:
- Parametrised successor to the stream-to-parallel collector.
- Gathers a beat stream of signed DATA_W words into a VEC_LEN-lane parallel vector.
- Full valid/ready on both sides; frame length set at run time; output register decouples the assembly buffer from the consumer; short and long frames are detected.
- Sits between the serial sample stream and the vector-wide compute stages.

Parameters:
- VEC_LEN, 3, maximum lanes per vector (>=1).
- DATA_W, 32, bits per lane.
- CNT_W, $clog2(VEC_LEN+1), width of the length and count fields (derived; do not override).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous active-high reset.
- cfg_len  in  CNT_W  expected beats per frame.
- s_valid  in  1  input beat valid.
- s_data  in  DATA_W  signed input beat.
- s_last  in  1  final beat of frame.
- s_ready  out  1  input can accept.
- m_valid  out  1  output vector valid.
- m_ready  in  1  consumer accepts.
- m_data_flat  out  VEC_LEN*DATA_W  lane i at bits [(i+1)*DATA_W-1 : i*DATA_W]; lane 0 is the first beat.
- m_count  out  CNT_W  lanes actually written.
- m_err_short  out  1  s_last arrived before cfg_len beats.
- m_err_long  out  1  cfg_len beats arrived without s_last.

Behaviour:
- Beat transfer: s_valid && s_ready. Output transfer: m_valid && m_ready.
- s_valid must hold until accepted.
- m_* outputs are registered and held stable while m_valid=1 && !m_ready.
- Reset: all outputs registered low or zero (m_valid, m_data_flat, m_count, m_err_short, m_err_long); state=FILL; write pointer=0; assembly lanes=0.
- s_ready is combinational from state: 1 in FILL and DROP, 0 in WAIT.
- Length latch: frame length L is latched from cfg_len on the first beat of each frame. cfg_len=0 or cfg_len>VEC_LEN gives L=VEC_LEN. cfg_len changes mid-frame are ignored.
- FILL:
  - Each accepted beat writes lane[ptr], then ptr+1.
  - Frame completes on the beat where s_last=1 or ptr+1==L.
  - Completion with s_last=1 and ptr+1<L: err_short=1; unwritten lanes forced to 0.
  - Completion with ptr+1==L and s_last=0: err_long=1; next state DROP.
  - Completion otherwise: next state FILL, or WAIT if the output register is not free.
- Output register free: m_valid=0, or m_ready=1 in the same cycle.
- Load: if free at completion, the output register loads in the same edge, including the completing beat. m_valid rises one cycle after the final beat is accepted (latency 1). ptr returns to 0. Back-to-back frames run at full rate with m_ready=1.
- WAIT: assembled frame is held and s_ready=0. When the output register frees, it loads, then the state goes to FILL, or to DROP if err_long.
- DROP: beats are accepted and discarded until a beat with s_last=1 is accepted, then FILL. That frame has already been emitted, so the tail produces no output.
- Single-beat frame: L=1, or s_last on the first beat. Emitted with m_count=1.
- m_count equals the number of beats written, 1..L.
- Synchronous rst mid-frame: partial frame discarded; pending m_valid cleared.

Optional Feature:
- Macro: STREAM_DESER_ERRCNT_EN.
- Defined:
  - Adds output port err_cnt, 16 bits, reset 0.
  - Increments once per emitted frame with m_err_short or m_err_long set, counted at output load time.
  - Saturates at 16'hFFFF.
  - Input clr_err_cnt (1 bit, synchronous) zeroes it; clr wins over a simultaneous increment.
- Undefined: neither port exists; no counter logic. All other behaviour identical.

Test Plan:
- Basic frame: VEC_LEN=3, cfg_len=3, beats 10,-20,30 with s_last on the third, m_ready=1 -> one cycle later m_valid=1, lanes {10,-20,30}, m_count=3, both error flags 0.
- Short frame: cfg_len=3, beats 5,6 with s_last on the second -> lanes {5,6,0}, m_count=2, m_err_short=1.
- Long frame with drop: cfg_len=2, beats 1,2,3,4 with s_last only on 4 -> one output {1,2,0}, m_count=2, m_err_long=1; beats 3,4 dropped; the next frame assembles normally.
- Backpressure: m_ready=0 while a second frame completes -> s_ready=0 in WAIT; first vector held stable; on m_ready=1 the second vector appears next cycle and s_ready returns to 1.
- Config edge: cfg_len=0, then cfg_len changed to 1 mid-frame -> frame length is 3; the cfg change is ignored.
- Reset mid-frame: rst after 2 beats -> all outputs 0; the next 3-beat frame gives the correct lanes. With STREAM_DESER_ERRCNT_EN, err_cnt counts 2 after the short and long cases and clears on clr_err_cnt.
